// File: rtl/rf_wb_scheduler_if.sv
// Write-back bus between the execution-unit requesters and the register file write port.
// The scheduler takes the slave side; the requesters and register file see the master side.
interface rf_wb_scheduler_if #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 32
);
    logic [NUM_REQ-1:0]      i_req_valid;
    logic [NUM_REQ*5-1:0]    i_req_addr;
    logic [NUM_REQ*XLEN-1:0] i_req_data;
    logic [NUM_REQ-1:0]      o_req_ready;
    logic [4:0]              o_rd_addr;
    logic [XLEN-1:0]         o_rd_data;
    logic                    o_rd_wen;

    modport master (
        output i_req_valid, i_req_addr, i_req_data,
        input  o_req_ready, o_rd_addr, o_rd_data, o_rd_wen
    );

    modport slave (
        input  i_req_valid, i_req_addr, i_req_data,
        output o_req_ready, o_rd_addr, o_rd_data, o_rd_wen
    );
endinterface

// File: rtl/rf_wb_scheduler.sv
// Round-robin write-back scheduler for the register file write port, plus a per-register
// busy scoreboard that clears on the same edge the register file commits the write.
module rf_wb_scheduler #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    rf_wb_scheduler_if.slave        wb,
    input  logic                    i_issue_valid,
    input  logic [4:0]              i_issue_rd,
    input  logic                    i_flush,
    input  logic [4:0]              i_rs1_addr,
    input  logic [4:0]              i_rs2_addr,
    output logic                    o_rs1_busy,
    output logic                    o_rs2_busy,
    output logic [31:0]             o_busy
);
    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   w_gidx;
    logic [PTR_W-1:0]   w_cand;
    logic [PTR_W-1:0]   w_ptr_next;
    logic [NUM_REQ-1:0] w_grant;
    logic               w_fire;
    logic [4:0]         w_sel_addr;
    logic [XLEN-1:0]    w_sel_data;

    logic               r_rd_wen;
    logic [4:0]         r_rd_addr;
    logic [XLEN-1:0]    r_rd_data;
    logic [31:0]        r_busy;
    logic [31:0]        w_busy_next;

    // Scan from the pointer upward with wrap; grant is suppressed entirely while in reset.
    always_comb begin
        int idx;
        idx     = 0;
        w_cand  = '0;
        w_gidx  = '0;
        w_fire  = 1'b0;
        w_grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(r_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            w_cand = PTR_W'(idx);
            if (!w_fire && wb.i_req_valid[w_cand]) begin
                w_fire = 1'b1;
                w_gidx = w_cand;
            end
        end
        if (!i_rst_n) begin
            w_fire = 1'b0;
        end
        if (w_fire) begin
            w_grant[w_gidx] = 1'b1;
        end
    end

    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_gidx == PTR_W'(k)) begin
                w_sel_addr = wb.i_req_addr[k*5 +: 5];
                w_sel_data = wb.i_req_data[k*XLEN +: XLEN];
            end
        end
        w_ptr_next = (int'(w_gidx) == NUM_REQ - 1) ? '0 : w_gidx + 1'b1;
    end

    // An x0 transfer still consumes the grant and moves the pointer, but never raises wen.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr     <= '0;
            r_rd_wen  <= 1'b0;
            r_rd_addr <= '0;
            r_rd_data <= '0;
        end else begin
            r_rd_wen <= w_fire && (w_sel_addr != 5'd0);
            if (w_fire) begin
                r_ptr     <= w_ptr_next;
                r_rd_addr <= w_sel_addr;
                r_rd_data <= w_sel_data;
            end
        end
    end

    // Flush beats a new issue, and a new issue beats the clear from a committing write.
    always_comb begin
        w_busy_next = r_busy;
        for (int r = 1; r < 32; r++) begin
            if (i_flush) begin
                w_busy_next[r] = 1'b0;
            end else if (i_issue_valid && (i_issue_rd == 5'(r))) begin
                w_busy_next[r] = 1'b1;
            end else if (r_rd_wen && (r_rd_addr == 5'(r))) begin
                w_busy_next[r] = 1'b0;
            end
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign wb.o_req_ready = w_grant;
    assign wb.o_rd_wen    = r_rd_wen;
    assign wb.o_rd_addr   = r_rd_addr;
    assign wb.o_rd_data   = r_rd_data;
    assign o_busy         = r_busy;
    assign o_rs1_busy     = r_busy[i_rs1_addr];
    assign o_rs2_busy     = r_busy[i_rs2_addr];
endmodule

// File: doc/rf_wb_scheduler.md
# rf_wb_scheduler

Write-back scheduler for the 32x32 register file. It shares the register file's single write port between NUM_REQ write-back requesters (ALU, load unit, mul/div) using round-robin arbitration and a valid/ready handshake, and drives the registered write port. It also keeps a per-register busy scoreboard so issue logic can stall on pending writes. It sits between the execution units and the register file write port.

## Interface
- NUM_REQ, 3, number of write-back requesters; legal range 2..4
- XLEN, 32, data width
- i_clk  in  1  clock; all state updates on the rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_req_valid  in  NUM_REQ  requester k holds a write-back
- i_req_addr  in  NUM_REQ*5  destination register of requester k, bits [5k+4:5k]
- i_req_data  in  NUM_REQ*XLEN  write data of requester k, bits [XLEN*k+XLEN-1:XLEN*k]
- o_req_ready  out  NUM_REQ  one-hot grant; transfer on valid&ready at the edge
- o_rd_addr  out  5  register file write address
- o_rd_data  out  XLEN  register file write data
- o_rd_wen  out  1  register file write enable
- i_issue_valid  in  1  an instruction writing i_issue_rd is issued this cycle
- i_issue_rd  in  5  destination register of the issued instruction
- i_flush  in  1  clear every busy bit
- i_rs1_addr, i_rs2_addr  in  5 each  source registers for hazard lookup
- o_rs1_busy, o_rs2_busy  out  1 each  source register has a pending write
- o_busy  out  32  full scoreboard; bit 0 always 0

## Operation
- Arbitration is combinational. Pointer ptr (width clog2(NUM_REQ)) names the highest-priority requester. Priority is ptr, ptr+1, ... mod NUM_REQ.
- o_req_ready is one-hot: it is the first valid requester in priority order, or all zero if no requester is valid. Ready never rises without valid.
- On an accepted transfer from requester k:
  - ptr <= (k+1) mod NUM_REQ.
  - The output register loads addr/data.
  - o_rd_wen <= (addr != 0).
- An x0 request is accepted and consumes the grant, but produces no write.
- With no transfer: ptr holds, o_rd_wen <= 0, and o_rd_addr/o_rd_data hold their last values.
- One write per cycle maximum. A new transfer is accepted every cycle; there is no back-pressure from the register file.
- Scoreboard busy[31:1]:
  - Set at the edge where i_issue_valid=1 and i_issue_rd!=0.
  - Cleared at the edge where o_rd_wen=1 for that address, i.e. when the write commits.
  - If set and clear hit the same register at the same edge, set wins.
- i_flush clears all busy bits at the edge and has priority over set. A write already in the output register still commits.
- o_rsN_busy = busy[i_rsN_addr]; address 0 always reads 0. This is a combinational lookup.
- Reset values:
  - o_rd_wen=0, o_rd_addr=0, o_rd_data=0.
  - ptr=0, all busy bits 0.
  - o_req_ready=0 while i_rst_n=0, regardless of valid.

## Timing
- Latency is 1 cycle: transfer at edge N puts o_rd_wen=1 during cycle N..N+1, and the register file writes at edge N+1.
- The busy bit clears at edge N+1, the same edge as the register file write. A reader therefore never sees busy=0 before the data is readable.
- o_req_ready depends combinationally on i_req_valid and ptr only. It does not depend on i_req_addr or i_req_data.
- Requester obligation: valid, addr and data stay stable until ready.
- Assertion of i_rst_n low at any time forces all state to reset values immediately, including mid-transfer. An in-flight write is dropped.
- Deassertion of reset takes effect at the next rising edge. No transfer is accepted in the cycle reset is low.

## Test plan
- Single requester: req0 valid with addr 5, data 0xDEADBEEF -> ready0=1 at once. Next cycle o_rd_wen=1, o_rd_addr=5, o_rd_data=0xDEADBEEF. The following cycle o_rd_wen=0.
- Round-robin: all three valid continuously from reset -> grant order 0,1,2,0,1,2. One o_rd_wen pulse per cycle with matching addr/data.
- x0 request: req1 valid with addr 0 -> ready1=1, ptr advances to 2, o_rd_wen stays 0.
- Scoreboard lifecycle:
  - Issue rd=7 -> o_busy[7]=1 next cycle and o_rs1_busy=1 for i_rs1_addr=7.
  - Write-back to 7 -> busy[7] clears at the edge ending the o_rd_wen cycle.
  - Issue rd=7 and commit to 7 at the same edge -> busy[7] stays 1.
- Flush: busy bits 3, 9 and 31 set, plus an in-flight write to 9; pulse i_flush -> o_busy=0 next cycle, and the write to 9 still appears on the port.
- Async reset mid-transfer: drop i_rst_n between edges while o_rd_wen=1 -> o_rd_wen, o_rd_addr, o_rd_data and o_busy go to 0 and o_req_ready goes to 0 immediately. After release, the first grant goes to req0.
